// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | regfile_wb_arbiter_if : writeback sources A/B and register-file port   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface regfile_wb_arbiter_if #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                       a_valid;
  logic                       a_ready;
  logic [ADDR_WIDTH-1:0]      a_reg;
  logic [DATA_WIDTH-1:0]      a_data;
  logic                       b_valid;
  logic                       b_ready;
  logic [ADDR_WIDTH-1:0]      b_reg;
  logic [DATA_WIDTH-1:0]      b_data;
  logic [ADDR_WIDTH-1:0]      write_reg;
  logic [DATA_WIDTH-1:0]      write_data;
  logic                       reg_write;
  logic [(2**ADDR_WIDTH)-1:0] pending_mask;
  logic [CNT_W-1:0]           a_count;
  logic [CNT_W-1:0]           b_count;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, write_reg, write_data, reg_write,
           pending_mask, a_count, b_count
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, write_reg, write_data, reg_write,
           pending_mask, a_count, b_count
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | regfile_wb_arbiter : round-robin merge of two queued writeback streams |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2 ** ADDR_WIDTH;
  localparam int NENT  = 2 * DEPTH;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [NREG-1:0]  C_ONE   = NREG'(1);

  // Index 0 is source A, index 1 is source B.
  logic [1:0]            w_valid;
  logic [1:0]            w_ready;
  logic [1:0]            w_push;
  logic [1:0]            w_grant;
  logic [1:0]            w_nonempty;
  logic [ADDR_WIDTH-1:0] w_in_reg   [2];
  logic [DATA_WIDTH-1:0] w_in_data  [2];
  logic [ADDR_WIDTH-1:0] w_head_reg [2];
  logic [DATA_WIDTH-1:0] w_head_data[2];
  logic [CNT_W-1:0]      w_count    [2];
  logic [NREG-1:0]       w_or       [NENT+1];

  logic                  r_last_b;
  logic                  r_reg_write;
  logic [ADDR_WIDTH-1:0] r_write_reg;
  logic [DATA_WIDTH-1:0] r_write_data;

  assign w_valid[0]   = bus.a_valid;
  assign w_valid[1]   = bus.b_valid;
  assign w_in_reg[0]  = bus.a_reg;
  assign w_in_reg[1]  = bus.b_reg;
  assign w_in_data[0] = bus.a_data;
  assign w_in_data[1] = bus.b_data;

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [ADDR_WIDTH-1:0] r_mem_reg  [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [DEPTH-1:0]      r_vld;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    assign w_ready[s]     = (r_count < C_DEPTH);
    // Register 0 completes the handshake but is never queued.
    assign w_push[s]      = w_valid[s] && w_ready[s] && (w_in_reg[s] != '0);
    assign w_nonempty[s]  = (r_count != '0);
    assign w_count[s]     = r_count;
    assign w_head_reg[s]  = r_mem_reg[r_rd_ptr];
    assign w_head_data[s] = r_mem_data[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld    <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_grant[s]) begin
          r_vld[r_rd_ptr] <= 1'b0;
          r_rd_ptr        <= r_rd_ptr + 1'b1;
        end
        if (w_push[s]) begin
          r_vld[r_wr_ptr] <= 1'b1;
          r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
        r_count <= r_count + CNT_W'(w_push[s]) - CNT_W'(w_grant[s]);
      end
    end

    always_ff @(posedge clk) begin
      if (w_push[s]) begin
        r_mem_reg[r_wr_ptr]  <= w_in_reg[s];
        r_mem_data[r_wr_ptr] <= w_in_data[s];
      end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      assign w_or[s*DEPTH+i+1] = w_or[s*DEPTH+i] |
                                 (r_vld[i] ? (C_ONE << r_mem_reg[i]) : '0);
    end
  end

  // A wins contention unless it was the last winner.
  assign w_grant[0] = w_nonempty[0] && (!w_nonempty[1] || r_last_b);
  assign w_grant[1] = w_nonempty[1] && !w_grant[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_b     <= 1'b1;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else if (w_grant != 2'b00) begin
      r_last_b     <= w_grant[1];
      r_reg_write  <= 1'b1;
      r_write_reg  <= w_grant[0] ? w_head_reg[0]  : w_head_reg[1];
      r_write_data <= w_grant[0] ? w_head_data[0] : w_head_data[1];
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  assign w_or[0] = r_reg_write ? (C_ONE << r_write_reg) : '0;

  assign bus.a_ready      = w_ready[0];
  assign bus.b_ready      = w_ready[1];
  assign bus.a_count      = w_count[0];
  assign bus.b_count      = w_count[1];
  assign bus.reg_write    = r_reg_write;
  assign bus.write_reg    = r_write_reg;
  assign bus.write_data   = r_write_data;
  assign bus.pending_mask = {w_or[NENT][NREG-1:1], 1'b0};
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_regfile_wb_arbiter : directed checks of the writeback arbiter      |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [4:0] out_q[$];

  regfile_wb_arbiter_if #(.DEPTH(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  regfile_wb_arbiter #(.DEPTH(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.reg_write) out_q.push_back(bus.write_reg);
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_reg   = '0;
    bus.b_reg   = '0;
    bus.a_data  = '0;
    bus.b_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_q.delete();
  endtask

  task automatic push_pair(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                           input logic bv, input logic [4:0] br, input logic [31:0] bd);
    bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
    bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
  endtask

  initial begin
    int ai;
    int bi;
    bit a_acc;
    bit b_acc;
    bit seen_full;
    int max_a;
    logic [4:0] exp_bp [8];

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();

    // Reset state
    @(posedge clk);
    #1;
    check("rst_we",    64'(bus.reg_write), 64'd0);
    check("rst_wreg",  64'(bus.write_reg), 64'd0);
    check("rst_wdata", 64'(bus.write_data), 64'd0);
    check("rst_mask",  64'(bus.pending_mask), 64'd0);
    check("rst_acnt",  64'(bus.a_count), 64'd0);
    check("rst_bcnt",  64'(bus.b_count), 64'd0);
    check("rst_ardy",  64'(bus.a_ready), 64'd1);
    check("rst_brdy",  64'(bus.b_ready), 64'd1);
    rst = 1'b0;

    // Single write: one-cycle latency onto the output register
    push_pair(1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    tick();
    idle_inputs();
    check("sw_acnt_q",  64'(bus.a_count), 64'd1);
    check("sw_we_q",    64'(bus.reg_write), 64'd0);
    check("sw_mask_q",  64'(bus.pending_mask), 64'h100);
    tick();
    check("sw_we",      64'(bus.reg_write), 64'd1);
    check("sw_wreg",    64'(bus.write_reg), 64'd8);
    check("sw_wdata",   64'(bus.write_data), 64'hDEAD_BEEF);
    check("sw_mask",    64'(bus.pending_mask), 64'h100);
    check("sw_acnt",    64'(bus.a_count), 64'd0);
    tick();
    check("sw_we_off",  64'(bus.reg_write), 64'd0);
    check("sw_mask_off",64'(bus.pending_mask), 64'd0);
    check("sw_hold",    64'(bus.write_reg), 64'd8);

    // Contention: A first after reset, then alternating
    do_reset();
    push_pair(1'b1, 5'd3, 32'hA000_0003, 1'b1, 5'd5, 32'hB000_0005);
    tick();
    check("ct_acnt", 64'(bus.a_count), 64'd1);
    check("ct_bcnt", 64'(bus.b_count), 64'd1);
    push_pair(1'b1, 5'd6, 32'hA000_0006, 1'b1, 5'd7, 32'hB000_0007);
    tick();
    idle_inputs();
    check("ct_reg0",  64'(bus.write_reg), 64'd3);
    check("ct_we0",   64'(bus.reg_write), 64'd1);
    check("ct_mask0", 64'(bus.pending_mask), 64'hE8);
    tick();
    check("ct_reg1",  64'(bus.write_reg), 64'd5);
    check("ct_data1", 64'(bus.write_data), 64'hB000_0005);
    tick();
    check("ct_reg2",  64'(bus.write_reg), 64'd6);
    tick();
    check("ct_reg3",  64'(bus.write_reg), 64'd7);
    check("ct_data3", 64'(bus.write_data), 64'hB000_0007);
    tick();
    check("ct_we_off", 64'(bus.reg_write), 64'd0);

    // Reset mid-stream discards queued writes
    do_reset();
    push_pair(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    tick();
    push_pair(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    tick();
    idle_inputs();
    check("mr_acnt_pre", 64'(bus.a_count), 64'd1);
    check("mr_bcnt_pre", 64'(bus.b_count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("mr_we",   64'(bus.reg_write), 64'd0);
    check("mr_acnt", 64'(bus.a_count), 64'd0);
    check("mr_bcnt", 64'(bus.b_count), 64'd0);
    check("mr_mask", 64'(bus.pending_mask), 64'd0);
    check("mr_ardy", 64'(bus.a_ready), 64'd1);
    check("mr_brdy", 64'(bus.b_ready), 64'd1);
    rst = 1'b0;
    out_q.delete();
    for (int k = 0; k < 4; k++) tick();
    check("mr_no_writes", 64'(out_q.size()), 64'd0);

    // Backpressure: both streams pushing, B fills and stalls
    do_reset();
    exp_bp = '{5'd10, 5'd20, 5'd11, 5'd21, 5'd12, 5'd22, 5'd13, 5'd23};
    ai = 0;
    bi = 0;
    seen_full = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      push_pair(ai < 4, 5'(10 + ai), 32'hA000_0000 + 32'(ai),
                bi < 4, 5'(20 + bi), 32'hB000_0000 + 32'(bi));
      a_acc = bus.a_valid && bus.a_ready;
      b_acc = bus.b_valid && bus.b_ready;
      if (!bus.b_ready && bus.b_count == 2'd2) seen_full = 1'b1;
      tick();
      if (a_acc) ai++;
      if (b_acc) bi++;
    end
    idle_inputs();
    check("bp_b_full", 64'(seen_full), 64'd1);
    check("bp_count",  64'(out_q.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < out_q.size()) check($sformatf("bp_out%0d", k), 64'(out_q[k]), 64'(exp_bp[k]));
    end

    // Register 0 is accepted and dropped
    do_reset();
    push_pair(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    check("r0_ardy", 64'(bus.a_ready), 64'd1);
    tick();
    idle_inputs();
    check("r0_acnt", 64'(bus.a_count), 64'd0);
    check("r0_mask", 64'(bus.pending_mask), 64'd0);
    tick();
    check("r0_we",   64'(bus.reg_write), 64'd0);

    // Wrap-around: ten writes streamed through A
    do_reset();
    max_a = 0;
    for (int i = 0; i < 12; i++) begin
      push_pair(i < 10, 5'(i + 1), 32'hC000_0000 + 32'(i + 1), 1'b0, 5'd0, 32'd0);
      tick();
      if (int'(bus.a_count) > max_a) max_a = int'(bus.a_count);
      if (i >= 1 && i <= 10) begin
        check($sformatf("wr_we%0d", i),  64'(bus.reg_write), 64'd1);
        check($sformatf("wr_reg%0d", i), 64'(bus.write_reg), 64'(i));
      end
    end
    idle_inputs();
    check("wr_we_end", 64'(bus.reg_write), 64'd0);
    check("wr_max_a",  64'(max_a), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
